// File: rtl/mem_pattern_checker.sv
// mem_pattern_checker
//
// Checks the test-memory read stream against a descending-by-one pattern
// (255, 254, ..., 0, 255, ...). The checker first locks onto the stream, then
// compares each valid sample with the predicted value. It counts mismatches
// (saturating) and completed sweeps (wrapping). The status word is driven to
// the LEDs.
//
// Parameters
//   LOCK_LEN  consecutive correct predictions needed to enter LOCKED (>= 1)
//   ERR_W     width of err_count (saturating)
//   SWEEP_W   width of sweep_count (wrapping)
//
// Ports
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset
//   valid        rd_data is sampled on this edge; all state holds when low
//   rd_data      8-bit memory read data
//   clear        synchronous clear of counters, sticky error and fail capture
//   locked       high while the checker is locked onto the pattern
//   error        sticky, set on any mismatch while locked
//   err_count    number of locked mismatches, saturating at all-ones
//   sweep_count  number of 0x00 samples matched while locked, wrapping
//   out_leds     {locked, error, err_count[5:0]}, zero-extended if ERR_W < 6
//
// Optional feature: define CHECKER_FAIL_CAPTURE_EN to add the following
// ports. They hold the predicted and received bytes of the first locked
// mismatch since reset or clear.
//   fail_valid   capture holds a mismatch
//   fail_exp     predicted byte of the first locked mismatch
//   fail_got     received byte of the first locked mismatch
module mem_pattern_checker #(
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8,
  parameter int SWEEP_W  = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               valid,
  input  logic [7:0]         rd_data,
  input  logic               clear,
  output logic               locked,
  output logic               error,
  output logic [ERR_W-1:0]   err_count,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic [7:0]         out_leds
`ifdef CHECKER_FAIL_CAPTURE_EN
  ,
  output logic               fail_valid,
  output logic [7:0]         fail_exp,
  output logic [7:0]         fail_got
`endif
);

  localparam int MW = $clog2(LOCK_LEN) + 1;
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_LEN);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [7:0]          exp_r, exp_nx_s;
  logic [MW-1:0]       match_cnt_r, match_nx_s;
  logic                hit_s;
  logic                err_evt_s;
  logic                sweep_evt_s;
  logic                locked_r;
  logic                error_r;
  logic [ERR_W-1:0]    err_count_r;
  logic [SWEEP_W-1:0]  sweep_count_r;
  logic [5:0]          err_led_s;

  // The successor of any sample in the pattern is the sample minus one, mod 256.
  function automatic logic [7:0] dec8(input logic [7:0] v);
    return v - 8'd1;
  endfunction

  // Next-state, prediction and event decode; everything holds without valid.
  always_comb begin
    state_nx_s  = state_r;
    exp_nx_s    = exp_r;
    match_nx_s  = match_cnt_r;
    err_evt_s   = 1'b0;
    sweep_evt_s = 1'b0;
    hit_s       = (rd_data == exp_r);
    if (valid) begin
      case (state_r)
        ST_SEARCH: begin
          exp_nx_s   = dec8(rd_data);
          match_nx_s = {MW{1'b0}};
          state_nx_s = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (hit_s) begin
            exp_nx_s   = dec8(exp_r);
            match_nx_s = match_cnt_r + MW'(1);
            if ((match_cnt_r + MW'(1)) == LOCK_TGT) begin
              state_nx_s = ST_LOCKED;
            end else begin
              state_nx_s = ST_ACQUIRE;
            end
          end else begin
            // Re-seed from the offending sample so a resumed stream re-locks fast.
            exp_nx_s   = dec8(rd_data);
            match_nx_s = {MW{1'b0}};
            state_nx_s = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (hit_s) begin
            exp_nx_s = dec8(exp_r);
            if (rd_data == 8'h00) begin
              sweep_evt_s = 1'b1;
            end else begin
              sweep_evt_s = 1'b0;
            end
          end else begin
            err_evt_s  = 1'b1;
            exp_nx_s   = dec8(rd_data);
            match_nx_s = {MW{1'b0}};
            state_nx_s = ST_ACQUIRE;
          end
        end
        default: begin
          state_nx_s = ST_SEARCH;
          exp_nx_s   = 8'h00;
          match_nx_s = {MW{1'b0}};
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM, prediction and lock indicator registers; clear does not touch these.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_SEARCH;
      exp_r       <= 8'h00;
      match_cnt_r <= {MW{1'b0}};
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      exp_r       <= exp_nx_s;
      match_cnt_r <= match_nx_s;
      locked_r    <= (state_nx_s == ST_LOCKED);
    end
  end

  // Error/sweep counters and sticky error; clear overrides any same-edge event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      error_r       <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
      sweep_count_r <= {SWEEP_W{1'b0}};
    end else if (clear) begin
      error_r       <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
      sweep_count_r <= {SWEEP_W{1'b0}};
    end else begin
      if (err_evt_s) begin
        error_r <= 1'b1;
        if (err_count_r != {ERR_W{1'b1}}) begin
          err_count_r <= err_count_r + ERR_W'(1);
        end
      end
      if (sweep_evt_s) begin
        sweep_count_r <= sweep_count_r + SWEEP_W'(1);
      end
    end
  end

`ifdef CHECKER_FAIL_CAPTURE_EN
  logic       fail_valid_r;
  logic [7:0] fail_exp_r;
  logic [7:0] fail_got_r;

  // First-mismatch capture; clear only invalidates it, the bytes are kept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fail_valid_r <= 1'b0;
      fail_exp_r   <= 8'h00;
      fail_got_r   <= 8'h00;
    end else if (clear) begin
      fail_valid_r <= 1'b0;
    end else if (err_evt_s && !fail_valid_r) begin
      fail_valid_r <= 1'b1;
      fail_exp_r   <= exp_r;
      fail_got_r   <= rd_data;
    end
  end

  assign fail_valid = fail_valid_r;
  assign fail_exp   = fail_exp_r;
  assign fail_got   = fail_got_r;
`endif

  // LED field is the low six bits of err_count, zero-extended for narrow counters.
  generate
    if (ERR_W >= 6) begin : g_led_wide
      assign err_led_s = err_count_r[5:0];
    end else begin : g_led_narrow
      assign err_led_s = {{(6 - ERR_W){1'b0}}, err_count_r};
    end
  endgenerate

  assign locked      = locked_r;
  assign error       = error_r;
  assign err_count   = err_count_r;
  assign sweep_count = sweep_count_r;
  assign out_leds    = {locked_r, error_r, err_led_s};

endmodule
